// File: rtl/rx_spi_pixel_recv.sv
// SPI slave receiver for one pixel lane: deserialises mode-0 MSB-first bytes and unpacks
// 3 bytes into 2 12-bit pixels, emitting a write strobe into the lane's Y memory.
module rx_spi_pixel_recv #(
  parameter int unsigned PIX_COUNT = 38400,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              Cclk,
  input  logic              rstn,
  input  logic              RxStart,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              CS_n,
  output logic              MISO,
  output logic              PixWe,
  output logic [ADDR_W-1:0] PixAdd,
  output logic [11:0]       PixData,
  output logic              FrameDone,
  output logic              RxBusy,
  output logic              RxErr
);

  localparam int unsigned        TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(PIX_COUNT - 1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e            r_state;
  state_e            w_state_nxt;

  logic              r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic              r_mosi_meta, r_mosi_sync;
  logic              r_cs_meta, r_cs_sync;
  logic              w_sclk_rise;

  logic [7:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic              r_byte_valid;

  logic [1:0]        r_phase;
  logic [7:0]        r_b0;
  logic [3:0]        r_nib;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_pix_we;
  logic [ADDR_W-1:0] r_pix_add;
  logic [11:0]       r_pix_data;
  logic              r_frame_done;
  logic              r_rx_err;

  logic              w_start;
  logic              w_last_we;
  logic              w_timeout;
  logic              w_accept;

  // Two-flop synchronisers; CS_n resets to its deasserted level.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
    end else begin
      r_sclk_meta <= SCLK;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_mosi_meta <= MOSI;
      r_mosi_sync <= r_mosi_meta;
      r_cs_meta   <= CS_n;
      r_cs_sync   <= r_cs_meta;
    end
  end

  assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_byte_valid <= 1'b0;
    end else if (r_cs_sync) begin
      r_bit_cnt    <= 3'd0;
      r_byte_valid <= 1'b0;
    end else if (w_sclk_rise) begin
      r_shift      <= {r_shift[6:0], r_mosi_sync};
      r_bit_cnt    <= r_bit_cnt + 3'd1;
      r_byte_valid <= (r_bit_cnt == 3'd7);
    end else begin
      r_byte_valid <= 1'b0;
    end
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_last_we   = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (RxStart) begin
          w_start     = 1'b1;
          w_state_nxt = StRecv;
        end
      end
      StRecv: begin
        if (RxStart) begin
          w_start     = 1'b1;
          w_state_nxt = StRecv;
        end else if (r_pix_we && (r_pix_add == LAST_ADDR)) begin
          w_last_we   = 1'b1;
          w_state_nxt = StIdle;
        end else if (!w_sclk_rise && (r_to_cnt == TO_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // A restart request takes priority over a byte completing in the same cycle.
  assign w_accept = (r_state == StRecv) && r_byte_valid && !RxStart;

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_phase      <= 2'd0;
      r_b0         <= 8'h00;
      r_nib        <= 4'h0;
      r_to_cnt     <= '0;
      r_pix_we     <= 1'b0;
      r_pix_add    <= '0;
      r_pix_data   <= 12'h000;
      r_frame_done <= 1'b0;
      r_rx_err     <= 1'b0;
    end else begin
      r_pix_we     <= 1'b0;
      r_frame_done <= w_last_we;
      if (w_start) begin
        r_pix_add <= '0;
        r_phase   <= 2'd0;
        r_to_cnt  <= '0;
        r_rx_err  <= 1'b0;
      end else begin
        if (w_timeout) begin
          r_rx_err <= 1'b1;
        end
        if (r_state == StRecv) begin
          r_to_cnt <= w_sclk_rise ? '0 : r_to_cnt + TO_W'(1);
        end
        if ((r_state == StRecv) && r_pix_we && !w_last_we) begin
          r_pix_add <= r_pix_add + ADDR_W'(1);
        end
        if (w_accept) begin
          case (r_phase)
            2'd0: begin
              r_b0    <= r_shift;
              r_phase <= 2'd1;
            end
            2'd1: begin
              r_pix_data <= {r_shift[3:0], r_b0};
              r_pix_we   <= 1'b1;
              r_nib      <= r_shift[7:4];
              r_phase    <= 2'd2;
            end
            default: begin
              r_pix_data <= {r_shift, r_nib};
              r_pix_we   <= 1'b1;
              r_phase    <= 2'd0;
            end
          endcase
        end
      end
    end
  end

  assign MISO      = 1'b0;
  assign PixWe     = r_pix_we;
  assign PixAdd    = r_pix_add;
  assign PixData   = r_pix_data;
  assign FrameDone = r_frame_done;
  assign RxBusy    = (r_state == StRecv);
  assign RxErr     = r_rx_err;

endmodule

// File: doc/rx_spi_pixel_recv.md
Name: rx_spi_pixel_recv

Overview:
Receive-side counterpart of the per-lane SPI pixel transmitter. Acts as SPI slave on one lane (SCLK/MOSI/CS_n in, MISO out), all in the Cclk domain. Deserialises bytes and unpacks the 3-bytes-per-2-pixels stream into 12-bit Y pixels. Emits a write port (address/data/enable) into one lane's Y memory, plus frame done/error status.

Parameters:
PIX_COUNT, 38400, pixels per lane per frame; must be even, ≥2.
ADDR_W, 16, pixel address width; PIX_COUNT ≤ 2^ADDR_W.
TIMEOUT, 4096, Cclk cycles with no SCLK rising edge in RECV before error.

Ports:
Cclk  in  1  system clock; all logic rising-edge.
rstn  in  1  asynchronous active-low reset.
RxStart  in  1  single-cycle pulse; arms reception of a new frame.
SCLK  in  1  SPI clock from transmitter (mode 0, MSB first).
MOSI  in  1  SPI data from transmitter.
CS_n  in  1  SPI chip select, active low.
MISO  out  1  tied 0.
PixWe  out  1  pixel write strobe, one Cclk wide.
PixAdd  out  ADDR_W  pixel write address.
PixData  out  12  pixel value.
FrameDone  out  1  one-cycle pulse after the last pixel write.
RxBusy  out  1  high in RECV.
RxErr  out  1  sticky timeout flag.

Behaviour:
- Reset values: MISO=0, PixWe=0, PixAdd=0, PixData=0, FrameDone=0, RxBusy=0, RxErr=0; FSM=IDLE, counters 0.
- Input sampling: SCLK, MOSI, CS_n each pass through 2-FF synchronisers. SCLK rise = synced SCLK 1 now, 0 previous cycle. Requires Cclk ≥ 4× SCLK.
- Bit capture: on SCLK rise with synced CS_n low, shift synced MOSI into an 8-bit register MSB first and increment the 3-bit bit counter.
  - Byte complete = 8th bit captured; raises internal ByteValid for one cycle.
- CS_n high: clears bit counter and discards any partial byte. Byte phase and address are preserved, so CS_n may toggle between bytes.
- FSM IDLE:
  - RxBusy=0; bytes are shifted but ByteValid is ignored.
  - RxStart -> RECV: PixAdd=0, byte phase=0, timeout counter=0, RxErr cleared.
- FSM RECV:
  - RxBusy=1. Byte phase cycles 0->1->2->0 on each ByteValid.
  - Phase 0: latch b0.
  - Phase 1: PixData={b1[3:0],b0}; pulse PixWe at current PixAdd; latch b1[7:4].
  - Phase 2: PixData={b2,b1[7:4]}; pulse PixWe.
  - PixAdd increments the cycle after each PixWe. PixWe asserts exactly 1 Cclk after the ByteValid cycle.
  - Write of pixel PIX_COUNT-1: FrameDone pulses on the cycle after that PixWe; FSM -> IDLE; PixAdd holds PIX_COUNT-1.
  - Timeout counter: cleared on every SCLK rise, else increments. Reaching TIMEOUT: RxErr=1, FSM -> IDLE, no FrameDone.
- RxStart while in RECV: restarts the frame, same as from IDLE. A write pending in the same cycle is dropped.
- RxStart coincident with ByteValid: RxStart wins; the byte is discarded.
- Async reset mid-byte or mid-frame returns every output to its reset value immediately.
- PixData holds its last value between strobes.

Test Plan:
- Reset then RxStart; send bytes 0x34,0x25,0x6A (CS_n low throughout, SCLK = Cclk/16) -> PixWe@0 data 0x534, PixWe@1 data 0x6A2; PixAdd=2 afterwards.
- Full frame of 57600 bytes with PIX_COUNT=38400, pattern pix[n]=n[11:0] -> 38400 writes with matching data, one FrameDone after addr 0x95FF write, RxBusy falls with it.
- CS_n deasserted after 5 bits of a byte, then full bytes 0xFF,0x0F,0x00 -> partial discarded; writes 0xFFF@0, 0x000@1.
- Bytes sent while IDLE (no RxStart) -> no PixWe, RxBusy=0.
- RxStart, 2 bytes, then SCLK stops for 4096 cycles -> RxErr=1, FSM IDLE, one PixWe only; next RxStart clears RxErr.
- Assert rstn low mid-frame at byte phase 2 -> all outputs 0 immediately; after release plus RxStart, the first 3 bytes produce addr 0 and addr 1 correctly.
